// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift unit: mode codes and FSM states.
package shift_pkg;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;
  localparam logic [1:0] SH_ROL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational shifter: moves the operand by k_i (0..STEP) bits in the selected mode
// and reports the last bit that left the word.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned STEP  = 1,
  parameter int unsigned KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  // A chain of STEP single-bit stages; stage j is bypassed when j >= k_i.
  // SRA keeps bit WIDTH-1 in place, so the original sign is replicated throughout.
  always_comb begin
    data_o  = data_i;
    carry_o = 1'b0;
    for (int unsigned j = 0; j < STEP; j++) begin
      if (j < 32'(k_i)) begin
        unique case (mode_i)
          SH_SLL: begin
            carry_o = data_o[WIDTH-1];
            data_o  = {data_o[WIDTH-2:0], 1'b0};
          end
          SH_SRL: begin
            carry_o = data_o[0];
            data_o  = {1'b0, data_o[WIDTH-1:1]};
          end
          SH_SRA: begin
            carry_o = data_o[0];
            data_o  = {data_o[WIDTH-1], data_o[WIDTH-1:1]};
          end
          SH_ROL: begin
            carry_o = data_o[WIDTH-1];
            data_o  = {data_o[WIDTH-2:0], data_o[WIDTH-1]};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: accepts an operand over valid/ready, shifts up to STEP bits per
// clock, then holds the result until the consumer takes it.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned STEP  = 1,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam int unsigned KW = $clog2(STEP + 1);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       mode_q;
  logic [SHW-1:0]   rem_q;
  logic             carry_q;
  logic             out_valid_q;

  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // k = min(STEP, rem); rem always fits in KW bits when it is below STEP.
  assign k = (32'(rem_q) < STEP) ? KW'(rem_q) : KW'(STEP);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_shift_step (
    .data_i  (data_q),
    .mode_i  (mode_q),
    .k_i     (k),
    .data_o  (step_data),
    .carry_o (step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      mode_q      <= SH_SLL;
      rem_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            mode_q  <= in_mode;
            rem_q   <= in_shamt;
            carry_q <= 1'b0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rem_q == '0) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            data_q  <= step_data;
            carry_q <= step_carry;
            rem_q   <= rem_q - SHW'(k);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: a STEP=1 and a STEP=4 instance driven from a vector table,
// random model-checked ops, backpressure and mid-shift reset sequences.
module tb_seq_shift_unit;
  import shift_pkg::*;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    int           lat;
  } exp_t;

  typedef struct {
    int           sel;
    logic [W-1:0] d;
    int           sh;
    logic [1:0]   m;
    logic [W-1:0] ed;
    logic         ec;
    int           el;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] in_data   [2];
  logic [5:0]   in_shamt  [2];
  logic [1:0]   in_mode   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_data  [2];
  logic         out_carry [2];

  seq_shift_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_shamt(in_shamt[0]), .in_mode(in_mode[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_carry(out_carry[0])
  );

  seq_shift_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_shamt(in_shamt[1]), .in_mode(in_mode[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_carry(out_carry[1])
  );

  int   checks = 0;
  int   passed = 0;
  exp_t sbq[$];
  vec_t tbl[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic exp_t model(input int step, input logic [W-1:0] d, input int sh,
                                 input logic [1:0] m);
    exp_t       e;
    logic [W-1:0] r;
    logic       c;
    r = d;
    c = 1'b0;
    for (int i = 0; i < sh; i++) begin
      case (m)
        SH_SLL:  begin c = r[W-1]; r = r << 1; end
        SH_SRL:  begin c = r[0];   r = r >> 1; end
        SH_SRA:  begin c = r[0];   r = $unsigned($signed(r) >>> 1); end
        default: begin c = r[W-1]; r = {r[W-2:0], r[W-1]}; end
      endcase
    end
    e.data  = r;
    e.carry = c;
    e.lat   = 1 + (sh + step - 1) / step;
    return e;
  endfunction

  // One complete transaction: accept, wait for result, optional hold with a stray request,
  // then handshake and confirm the unit returns to idle with the result retained.
  task automatic run_op(input int sel, input logic [W-1:0] d, input int sh,
                        input logic [1:0] m, input exp_t e, input int hold, input bit poke);
    int   n;
    exp_t g;
    n = 0;
    @(negedge clk);
    while (!in_ready[sel] && n < 100) begin @(negedge clk); n++; end
    check("in_ready_before_op", 64'(in_ready[sel]), 64'd1);
    in_valid[sel] = 1'b1;
    in_data[sel]  = d;
    in_shamt[sel] = 6'(sh);
    in_mode[sel]  = m;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    in_data[sel]  = ~d;
    n = 0;
    while (!out_valid[sel] && n < 200) begin @(posedge clk); #1; n++; end
    g = sbq.pop_front();
    check("latency", 64'(n), 64'(g.lat));
    check("out_data", out_data[sel], g.data);
    check("out_carry", 64'(out_carry[sel]), 64'(g.carry));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid[sel] = poke && (i == 1);
      in_shamt[sel] = 6'd0;
      @(posedge clk);
      #1;
      check("hold_out_valid", 64'(out_valid[sel]), 64'd1);
      check("hold_out_data", out_data[sel], g.data);
      check("hold_out_carry", 64'(out_carry[sel]), 64'(g.carry));
      check("hold_in_ready", 64'(in_ready[sel]), 64'd0);
    end
    @(negedge clk);
    in_valid[sel]  = 1'b0;
    out_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[sel] = 1'b0;
    check("post_out_valid", 64'(out_valid[sel]), 64'd0);
    check("post_in_ready", 64'(in_ready[sel]), 64'd1);
    check("retained_data", out_data[sel], g.data);
  endtask

  initial begin
    exp_t         e;
    logic [W-1:0] d;
    int           sh;
    logic [1:0]   m;
    int           sel;

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = '0;
      in_shamt[i] = '0;   in_mode[i] = SH_SLL;
    end

    tbl[0]  = '{0, 64'h0FF9, 1, SH_SLL, 64'h1FF2, 1'b0, 2};
    tbl[1]  = '{0, 64'h6A9A, 3, SH_SRL, 64'h0D53, 1'b0, 4};
    tbl[2]  = '{1, 64'h8000_0000_0000_0000, 4, SH_SRA, 64'hF800_0000_0000_0000, 1'b0, 2};
    tbl[3]  = '{1, 64'h8000_0000_0000_0000, 5, SH_SRA, 64'hFC00_0000_0000_0000, 1'b0, 3};
    tbl[4]  = '{0, 64'h8000_0000_0000_0001, 1, SH_ROL, 64'h3, 1'b1, 2};
    tbl[5]  = '{0, 64'h1234, 0, SH_SRA, 64'h1234, 1'b0, 1};
    tbl[6]  = '{1, 64'hDEAD_BEEF_0000_0001, 0, SH_ROL, 64'hDEAD_BEEF_0000_0001, 1'b0, 1};
    tbl[7]  = '{1, 64'h8000_0000_0000_0003, 63, SH_SLL, 64'h8000_0000_0000_0000, 1'b1, 17};
    tbl[8]  = '{0, 64'h8000_0000_0000_0003, 63, SH_SRL, 64'h1, 1'b0, 64};
    tbl[9]  = '{1, 64'h1234_5678_9ABC_DEF0, 4, SH_ROL, 64'h2345_6789_ABCD_EF01, 1'b1, 2};
    tbl[10] = '{1, 64'hF0, 5, SH_SRL, 64'h7, 1'b1, 3};
    tbl[11] = '{0, 64'h4000_0000_0000_0002, 2, SH_SRA, 64'h1000_0000_0000_0000, 1'b1, 3};

    // Reset state
    #12;
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", 64'(in_ready[i]), 64'd0);
      check("rst_out_valid", 64'(out_valid[i]), 64'd0);
      check("rst_out_data", out_data[i], 64'd0);
      check("rst_out_carry", 64'(out_carry[i]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready0", 64'(in_ready[0]), 64'd1);
    check("rel_in_ready1", 64'(in_ready[1]), 64'd1);

    foreach (tbl[i]) begin
      e.data = tbl[i].ed; e.carry = tbl[i].ec; e.lat = tbl[i].el;
      run_op(tbl[i].sel, tbl[i].d, tbl[i].sh, tbl[i].m, e, 0, 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      sel = i % 2;
      d   = {$urandom(), $urandom()};
      sh  = $urandom_range(0, 63);
      m   = 2'($urandom_range(0, 3));
      e   = model((sel == 0) ? 1 : 4, d, sh, m);
      run_op(sel, d, sh, m, e, 0, 1'b0);
    end

    // Backpressure with a stray request during the hold
    e = model(1, 64'hA5A5_0000_FFFF_1234, 7, SH_ROL);
    run_op(0, 64'hA5A5_0000_FFFF_1234, 7, SH_ROL, e, 5, 1'b1);
    e = model(4, 64'h8123_4567_89AB_CDEF, 9, SH_SRA);
    run_op(1, 64'h8123_4567_89AB_CDEF, 9, SH_SRA, e, 5, 1'b1);

    // Reset in the middle of a long shift
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 64'h5; in_shamt[0] = 6'd40; in_mode[0] = SH_SLL;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_out_data", out_data[0], 64'd0);
    check("midrst_in_ready", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_rel_in_ready", 64'(in_ready[0]), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_emit", 64'(out_valid[0]), 64'd0);
    e = model(1, 64'h0000_0000_0000_00C3, 6, SH_SLL);
    run_op(0, 64'h0000_0000_0000_00C3, 6, SH_SLL, e, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
    $fatal(1);
  end

endmodule
